scalar_alu_arbiter: RTL and testbench

Two-requester arbiter and issue pipeline that shares the single scalar ALU (add/sub/xor/ror, 4-bit NZVC flags) between the scalar control path and the vector unit's scalar-operand path. It accepts at most one operation per cycle from either requester using round-robin arbitration. A requester may lock the ALU across back-to-back operations, for example chained cipher rounds. The block drives the ALU's operand and control inputs from registered stage-1 operands and returns the registered result and flags, tagged with the requester id.

---
 rtl/scalar_alu_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_scalar_alu_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scalar_alu_arbiter.sv
// ============================================================================
// Module   : scalar_alu_arbiter
// Brief    : Round-robin, lockable two-requester issue pipeline for the
//            shared scalar ALU; registered operands out, tagged result back.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module scalar_alu_arbiter #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_stall,

    input  logic         i_req0_valid,
    output logic         o_req0_ready,
    input  logic         i_req0_lock,
    input  logic [N-1:0] i_req0_a,
    input  logic [N-1:0] i_req0_b,
    input  logic [1:0]   i_req0_op,

    input  logic         i_req1_valid,
    output logic         o_req1_ready,
    input  logic         i_req1_lock,
    input  logic [N-1:0] i_req1_a,
    input  logic [N-1:0] i_req1_b,
    input  logic [1:0]   i_req1_op,

    output logic [N-1:0] o_alu_a,
    output logic [N-1:0] o_alu_b,
    output logic [1:0]   o_alu_ctrl,
    input  logic [N-1:0] i_alu_res,
    input  logic [3:0]   i_alu_flags,

    output logic         o_resp_valid,
    output logic         o_resp_id,
    output logic [N-1:0] o_resp_res,
    output logic [3:0]   o_resp_flags,
    output logic         o_busy
);

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } state_t;

    state_t       r_st;
    state_t       w_st_nxt;
    logic         r_prio;

    logic         w_gnt0;
    logic         w_gnt1;
    logic         w_hs0;
    logic         w_hs1;
    logic         w_hs;

    logic         r_s1_v;
    logic         r_s1_id;
    logic [N-1:0] r_alu_a;
    logic [N-1:0] r_alu_b;
    logic [1:0]   r_alu_ctrl;

    logic         r_resp_valid;
    logic         r_resp_id;
    logic [N-1:0] r_resp_res;
    logic [3:0]   r_resp_flags;

    logic [N-1:0] w_sel_a;
    logic [N-1:0] w_sel_b;
    logic [1:0]   w_sel_op;

    // ------------------------------------------------------------------------
    // Grant: a grant is only offered to a requester that is presenting a
    // request, so ready doubles as "this requester wins this cycle".
    // ------------------------------------------------------------------------
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!i_stall) begin
            case (r_st)
                ST_LOCK0: w_gnt0 = i_req0_valid;
                ST_LOCK1: w_gnt1 = i_req1_valid;
                default: begin
                    if (i_req0_valid && i_req1_valid) begin
                        w_gnt0 = ~r_prio;
                        w_gnt1 = r_prio;
                    end else begin
                        w_gnt0 = i_req0_valid;
                        w_gnt1 = i_req1_valid;
                    end
                end
            endcase
        end
    end

    assign o_req0_ready = w_gnt0 & ~rst;
    assign o_req1_ready = w_gnt1 & ~rst;

    assign w_hs0 = i_req0_valid & o_req0_ready;
    assign w_hs1 = i_req1_valid & o_req1_ready;
    assign w_hs  = w_hs0 | w_hs1;

    // ------------------------------------------------------------------------
    // Lock tracking: a lock is released on any edge where its owner drops
    // lock, independent of stall or whether the owner is issuing.
    // ------------------------------------------------------------------------
    always_comb begin
        w_st_nxt = r_st;
        case (r_st)
            ST_ARB: begin
                if (w_hs0 && i_req0_lock) begin
                    w_st_nxt = ST_LOCK0;
                end else if (w_hs1 && i_req1_lock) begin
                    w_st_nxt = ST_LOCK1;
                end
            end
            ST_LOCK0: begin
                if (!i_req0_lock) begin
                    w_st_nxt = ST_ARB;
                end
            end
            ST_LOCK1: begin
                if (!i_req1_lock) begin
                    w_st_nxt = ST_ARB;
                end
            end
            default: w_st_nxt = ST_ARB;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_st <= ST_ARB;
        end else begin
            r_st <= w_st_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prio <= 1'b0;
        end else if (w_hs0) begin
            r_prio <= 1'b1;
        end else if (w_hs1) begin
            r_prio <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Stage 1: operand registers feeding the ALU directly.
    // ------------------------------------------------------------------------
    assign w_sel_a  = w_hs1 ? i_req1_a  : i_req0_a;
    assign w_sel_b  = w_hs1 ? i_req1_b  : i_req0_b;
    assign w_sel_op = w_hs1 ? i_req1_op : i_req0_op;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_v     <= 1'b0;
            r_s1_id    <= 1'b0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_ctrl <= 2'b00;
        end else if (w_hs) begin
            r_s1_v     <= 1'b1;
            r_s1_id    <= w_hs1;
            r_alu_a    <= w_sel_a;
            r_alu_b    <= w_sel_b;
            r_alu_ctrl <= w_sel_op;
        end else begin
            r_s1_v     <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Stage 2: capture the combinational ALU result; never back-pressured.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_resp_valid <= 1'b0;
            r_resp_id    <= 1'b0;
            r_resp_res   <= '0;
            r_resp_flags <= 4'b0000;
        end else begin
            r_resp_valid <= r_s1_v;
            r_resp_id    <= r_s1_id;
            if (r_s1_v) begin
                r_resp_res   <= i_alu_res;
                r_resp_flags <= i_alu_flags;
            end
        end
    end

    assign o_alu_a      = r_alu_a;
    assign o_alu_b      = r_alu_b;
    assign o_alu_ctrl   = r_alu_ctrl;
    assign o_resp_valid = r_resp_valid;
    assign o_resp_id    = r_resp_id;
    assign o_resp_res   = r_resp_res;
    assign o_resp_flags = r_resp_flags;
    assign o_busy       = r_s1_v | r_resp_valid;

endmodule

`default_nettype wire

// File: tb/tb_scalar_alu_arbiter.sv
// ============================================================================
// Module   : tb_scalar_alu_arbiter
// Brief    : Directed + randomized bench with transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_scalar_alu_arbiter;

    localparam int c_N = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           i_stall;
    logic           v0, v1, l0, l1;
    logic [c_N-1:0] a0, b0, a1, b1;
    logic [1:0]     op0, op1;
    logic           o_req0_ready, o_req1_ready;
    logic [c_N-1:0] o_alu_a, o_alu_b;
    logic [1:0]     o_alu_ctrl;
    logic [c_N-1:0] w_alu_res;
    logic [3:0]     w_alu_flags;
    logic           o_resp_valid, o_resp_id, o_busy;
    logic [c_N-1:0] o_resp_res;
    logic [3:0]     o_resp_flags;

    always #5 clk = ~clk;

    scalar_alu_arbiter #(.N(c_N)) u_dut (
        .clk(clk), .rst(rst), .i_stall(i_stall),
        .i_req0_valid(v0), .o_req0_ready(o_req0_ready), .i_req0_lock(l0),
        .i_req0_a(a0), .i_req0_b(b0), .i_req0_op(op0),
        .i_req1_valid(v1), .o_req1_ready(o_req1_ready), .i_req1_lock(l1),
        .i_req1_a(a1), .i_req1_b(b1), .i_req1_op(op1),
        .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_ctrl(o_alu_ctrl),
        .i_alu_res(w_alu_res), .i_alu_flags(w_alu_flags),
        .o_resp_valid(o_resp_valid), .o_resp_id(o_resp_id),
        .o_resp_res(o_resp_res), .o_resp_flags(o_resp_flags), .o_busy(o_busy)
    );

    // Behavioural ALU: returns {N,Z,V,C, result}.
    function automatic logic [35:0] alu_fn(logic [31:0] a, logic [31:0] b, logic [1:0] op);
        logic [32:0] s;
        logic [63:0] d;
        logic [31:0] r;
        logic        c, v;
        c = 1'b0;
        v = 1'b0;
        case (op)
            2'b00: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[31:0];
                c = s[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            2'b01: begin
                r = a - b;
                c = (a >= b);
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            2'b10: r = a ^ b;
            default: begin
                d = {a, a} >> b[4:0];
                r = d[31:0];
                c = r[31];
            end
        endcase
        return {r[31], (r == 32'd0), v, c, r};
    endfunction

    assign {w_alu_flags, w_alu_res} = alu_fn(o_alu_a, o_alu_b, o_alu_ctrl);

    typedef struct {
        int          due;
        logic        id;
        logic [31:0] res;
        logic [3:0]  fl;
    } rsp_t;

    rsp_t        q[$];
    int          lk;
    logic        pr;
    int          cyc;
    logic [31:0] m_a, m_b, m_res;
    logic [1:0]  m_ctrl;
    logic [3:0]  m_fl;
    logic        hs0, hs1;
    int          n_checks;
    int          n_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        q.delete();
        lk     = -1;
        pr     = 1'b0;
        m_a    = '0;
        m_b    = '0;
        m_ctrl = 2'b00;
        m_res  = '0;
        m_fl   = 4'b0000;
    endtask

    // One clock: inputs already driven; checks grants, advances model, checks outputs.
    task automatic step();
        logic        e0, e1, exp_v, exp_b;
        logic [35:0] rr;
        rsp_t        t;
        #1;
        e0 = 1'b0;
        e1 = 1'b0;
        if (!i_stall) begin
            if (lk == 0)             e0 = v0;
            else if (lk == 1)        e1 = v1;
            else if (v0 && v1) begin e0 = ~pr; e1 = pr; end
            else begin               e0 = v0; e1 = v1; end
        end
        chk("ready0", o_req0_ready, e0);
        chk("ready1", o_req1_ready, e1);
        hs0 = e0;
        hs1 = e1;
        @(posedge clk);
        cyc++;
        if (hs0 || hs1) begin
            m_a    = hs1 ? a1 : a0;
            m_b    = hs1 ? b1 : b0;
            m_ctrl = hs1 ? op1 : op0;
            rr     = alu_fn(m_a, m_b, m_ctrl);
            q.push_back('{due: cyc + 1, id: hs1, res: rr[31:0], fl: rr[35:32]});
            pr = hs0;
        end
        if (lk < 0) begin
            if (hs0 && l0)      lk = 0;
            else if (hs1 && l1) lk = 1;
        end else if ((lk == 0 && !l0) || (lk == 1 && !l1)) begin
            lk = -1;
        end
        @(negedge clk);
        exp_v = (q.size() > 0) && (q[0].due == cyc);
        chk("resp_valid", o_resp_valid, exp_v);
        if (exp_v) begin
            t     = q.pop_front();
            m_res = t.res;
            m_fl  = t.fl;
            chk("resp_id", o_resp_id, t.id);
        end
        exp_b = exp_v || ((q.size() > 0) && (q[0].due == cyc + 1));
        chk("resp_res", o_resp_res, m_res);
        chk("resp_flags", o_resp_flags, m_fl);
        chk("busy", o_busy, exp_b);
        chk("alu_a", o_alu_a, m_a);
        chk("alu_b", o_alu_b, m_b);
        chk("alu_ctrl", o_alu_ctrl, m_ctrl);
    endtask

    // Short reset pulse inside the low clock phase; valids raised to prove readies are gated.
    task automatic do_reset();
        rst = 1'b1;
        v0  = 1'b1;
        v1  = 1'b1;
        #1;
        chk("rst_ready0", o_req0_ready, 0);
        chk("rst_ready1", o_req1_ready, 0);
        chk("rst_resp_valid", o_resp_valid, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_resp_id", o_resp_id, 0);
        chk("rst_resp_res", o_resp_res, 0);
        chk("rst_resp_flags", o_resp_flags, 0);
        chk("rst_alu_a", o_alu_a, 0);
        chk("rst_alu_b", o_alu_b, 0);
        chk("rst_alu_ctrl", o_alu_ctrl, 0);
        v0  = 1'b0;
        v1  = 1'b0;
        model_reset();
        #1;
        rst = 1'b0;
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h7FFF_FFFF;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h0000_0000;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic p0, p1;
        n_checks = 0;
        n_err    = 0;
        cyc      = 0;
        rst      = 1'b1;
        i_stall  = 1'b0;
        {v0, v1, l0, l1} = 4'b0000;
        {a0, b0, a1, b1} = '0;
        op0 = 2'b00;
        op1 = 2'b00;
        model_reset();
        @(negedge clk);
        do_reset();

        // Single add on requester 0
        v0 = 1'b1; a0 = 32'd5; b0 = 32'd3; op0 = 2'b00;
        step();
        v0 = 1'b0;
        step();
        chk("single_valid", o_resp_valid, 1);
        chk("single_res", o_resp_res, 32'd8);
        chk("single_id", o_resp_id, 0);
        step();

        // Contention from fresh reset: strict alternation
        do_reset();
        v0 = 1'b1; a0 = 32'h11; b0 = 32'h22; op0 = 2'b10;
        v1 = 1'b1; a1 = 32'h1234_5678; b1 = 32'd4; op1 = 2'b11;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("alt_grant", {31'd0, hs1}, i % 2);
        end
        v0 = 1'b0; v1 = 1'b0;
        step(); step();

        // Overflow and zero-flag pass-through on requester 1
        v1 = 1'b1; a1 = 32'h7FFF_FFFF; b1 = 32'd1; op1 = 2'b00;
        step();
        v1 = 1'b0;
        step();
        chk("ovf_res", o_resp_res, 32'h8000_0000);
        chk("ovf_N", o_resp_flags[3], 1);
        chk("ovf_V", o_resp_flags[1], 1);
        v1 = 1'b1; a1 = 32'd5; b1 = 32'd5; op1 = 2'b01;
        step();
        v1 = 1'b0;
        step();
        chk("sub_res", o_resp_res, 0);
        chk("sub_Z", o_resp_flags[2], 1);

        // Lock: requester 0 chains four ops while requester 1 waits
        v1 = 1'b1; l1 = 1'b0; a1 = 32'hA5A5_A5A5; b1 = 32'h5A5A_5A5A; op1 = 2'b10;
        for (int i = 0; i < 4; i++) begin
            v0 = 1'b1; l0 = (i < 3); a0 = $urandom; b0 = $urandom; op0 = 2'(i);
            step();
            chk("lock_gnt0", hs0, 1);
        end
        v0 = 1'b0; l0 = 1'b0;
        step();
        chk("lock_gnt1_after", hs1, 1);
        v1 = 1'b0;
        step(); step();

        // Stall right after an accepted op
        v0 = 1'b1; a0 = 32'd100; b0 = 32'd1; op0 = 2'b01;
        step();
        i_stall = 1'b1;
        v0 = 1'b1; a0 = 32'd7; b0 = 32'd9;
        v1 = 1'b1; a1 = 32'd3; b1 = 32'd2;
        step();
        chk("stall_resp", o_resp_valid, 1);
        step();
        chk("stall_busy0", o_busy, 0);
        step();
        i_stall = 1'b0;
        v0 = 1'b0; v1 = 1'b0;
        step(); step();

        // Reset while an op and a lock are in flight
        v0 = 1'b1; l0 = 1'b1; a0 = 32'hDEAD; b0 = 32'hBEEF; op0 = 2'b00;
        step();
        v0 = 1'b0;
        do_reset();
        step();
        chk("rstmid_no_resp", o_resp_valid, 0);
        step();
        v1 = 1'b1; a1 = 32'd1; b1 = 32'd2; op1 = 2'b00;
        step();
        chk("rstmid_unlocked", hs1, 1);
        v1 = 1'b0; l0 = 1'b0;
        step(); step();

        // Randomized traffic; a pending request holds its payload until accepted
        p0 = 1'b0;
        p1 = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (!p0) begin
                v0 = ($urandom_range(0, 3) != 0);
                a0 = rnd_operand(); b0 = rnd_operand(); op0 = 2'($urandom_range(0, 3));
            end
            if (!p1) begin
                v1 = ($urandom_range(0, 3) != 0);
                a1 = rnd_operand(); b1 = rnd_operand(); op1 = 2'($urandom_range(0, 3));
            end
            l0 = ($urandom_range(0, 2) == 0);
            l1 = ($urandom_range(0, 2) == 0);
            i_stall = ($urandom_range(0, 5) == 0);
            step();
            p0 = v0 && !hs0;
            p1 = v1 && !hs1;
        end
        v0 = 1'b0; v1 = 1'b0; i_stall = 1'b0; l0 = 1'b0; l1 = 1'b0;
        step(); step(); step();
        chk("drain_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule

`default_nettype wire
